// File: rtl/uart_pkg.sv
// Shared UART definitions: default line timing and the TX arbiter state encoding.
package uart_pkg;

    localparam int unsigned CLKS_PER_BIT = 87;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned ARB_STATE_W  = 3;

    typedef enum logic [ARB_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_GAP       = 3'd3,
        ST_HOLD      = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker: first set bit of req searching upward from ptr+1, wrapping.
module rr_select #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int unsigned W = $clog2(N);

    always_comb begin
        int unsigned  pos;
        logic [W-1:0] cand;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        // ptr itself is visited last, so the most recently served index has lowest priority
        for (int unsigned k = 1; k <= N; k++) begin
            pos  = (32'(ptr) + k) % N;
            cand = W'(pos);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with optional multi-byte packet locking and an idle-lock timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned LOCK_TIMEOUT = 1023
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst,
    input  logic [NUM_REQ-1:0]         i_Req_Valid,
    input  logic [8*NUM_REQ-1:0]       i_Req_Byte,
    input  logic [NUM_REQ-1:0]         i_Req_Last,
    output logic [NUM_REQ-1:0]         o_Req_Ack,
    output logic                       o_TX_DV,
    output logic [7:0]                 o_TX_Byte,
    input  logic                       i_TX_Done,
    output logic [$clog2(NUM_REQ)-1:0] o_Grant_Idx,
    output logic                       o_Locked,
    output logic                       o_Busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMO_W = (LOCK_TIMEOUT == 0) ? 1 : $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(LOCK_TIMEOUT);
    localparam bit TMO_EN = (LOCK_TIMEOUT != 0);

    arb_state_e          state_q;
    logic [IDX_W-1:0]    rr_ptr_q;
    logic [IDX_W-1:0]    grant_q;
    logic                last_q;
    logic                locked_q;
    logic                busy_q;
    logic                tx_dv_q;
    logic [BYTE_W-1:0]   tx_byte_q;
    logic [NUM_REQ-1:0]  ack_q;
    logic [TMO_W-1:0]    tmo_cnt_q;
    logic [TMO_W-1:0]    tmo_cnt_d;

    logic [BYTE_W-1:0]   req_bytes_c [NUM_REQ];
    logic [IDX_W-1:0]    sel_idx_c;
    logic                sel_found_c;
    logic [IDX_W-1:0]    issue_idx_c;
    logic                issue_go_c;

    rr_select #(
        .N (NUM_REQ)
    ) u_rr_select (
        .req   (i_Req_Valid),
        .ptr   (rr_ptr_q),
        .idx   (sel_idx_c),
        .found (sel_found_c)
    );

    // Unpack the flat byte bus into per-requester lanes.
    always_comb begin
        for (int unsigned n = 0; n < NUM_REQ; n++) begin
            req_bytes_c[n] = i_Req_Byte[8*n +: 8];
        end
    end

    // A byte is launched from IDLE via the picker, or from HOLD only by the locked owner.
    always_comb begin
        issue_idx_c = sel_idx_c;
        issue_go_c  = 1'b0;
        if (state_q == ST_IDLE) begin
            issue_idx_c = sel_idx_c;
            issue_go_c  = sel_found_c;
        end else if (state_q == ST_HOLD) begin
            issue_idx_c = grant_q;
            issue_go_c  = i_Req_Valid[grant_q];
        end
    end

    assign tmo_cnt_d = tmo_cnt_q + TMO_W'(1);

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            last_q    <= 1'b0;
            locked_q  <= 1'b0;
            busy_q    <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= '0;
            ack_q     <= '0;
            tmo_cnt_q <= '0;
        end else begin
            tx_dv_q <= 1'b0;
            ack_q   <= '0;
            if (issue_go_c) begin
                // DV and Ack are registered here so both are high for the whole ISSUE cycle
                grant_q   <= issue_idx_c;
                tx_byte_q <= req_bytes_c[issue_idx_c];
                last_q    <= i_Req_Last[issue_idx_c];
                tx_dv_q   <= 1'b1;
                ack_q     <= NUM_REQ'(1) << issue_idx_c;
                state_q   <= ST_ISSUE;
                busy_q    <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        busy_q <= 1'b0;
                    end
                    ST_ISSUE: begin
                        if (last_q) begin
                            locked_q <= 1'b0;
                            rr_ptr_q <= grant_q;
                        end else begin
                            locked_q <= 1'b1;
                        end
                        state_q <= ST_WAIT_DONE;
                    end
                    ST_WAIT_DONE: begin
                        if (i_TX_Done) begin
                            state_q <= ST_GAP;
                        end
                    end
                    ST_GAP: begin
                        tmo_cnt_q <= '0;
                        if (locked_q) begin
                            state_q <= ST_HOLD;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                    ST_HOLD: begin
                        // Silent owner: release once the idle count reaches the limit.
                        if (TMO_EN && (tmo_cnt_d == TMO_LIMIT)) begin
                            locked_q <= 1'b0;
                            rr_ptr_q <= grant_q;
                            state_q  <= ST_IDLE;
                            busy_q   <= 1'b0;
                        end else if (TMO_EN) begin
                            tmo_cnt_q <= tmo_cnt_d;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_Req_Ack   = ack_q;
    assign o_TX_DV     = tx_dv_q;
    assign o_TX_Byte   = tx_byte_q;
    assign o_Grant_Idx = grant_q;
    assign o_Locked    = locked_q;
    assign o_Busy      = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed fairness/lock/reset/timeout cases plus random packets.
module tb_uart_tx_arbiter;

    localparam int unsigned NUM_REQ      = 4;
    localparam int unsigned LOCK_TIMEOUT = 5;
    localparam int unsigned IDX_W        = 2;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [7:0]       data;
        logic             first;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   ack;
    logic                 tx_dv;
    logic [7:0]           tx_byte;
    logic                 tx_done;
    logic [IDX_W-1:0]     grant;
    logic                 locked;
    logic                 busy;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    bit   have_done = 1'b0;
    bit   tx_auto = 1'b1;
    int   total_bytes = 0;
    int   model_ptr = NUM_REQ - 1;

    exp_t       exp_q [$];
    logic [8:0] rq [NUM_REQ][$];
    logic [8:0] mq [NUM_REQ][$];

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .i_Clock     (clk),
        .i_Rst       (rst),
        .i_Req_Valid (req_valid),
        .i_Req_Byte  (req_byte),
        .i_Req_Last  (req_last),
        .o_Req_Ack   (ack),
        .o_TX_DV     (tx_dv),
        .o_TX_Byte   (tx_byte),
        .i_TX_Done   (tx_done),
        .o_Grant_Idx (grant),
        .o_Locked    (locked),
        .o_Busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic finish_sim();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic push_req(input int r, input logic [7:0] b, input logic last);
        rq[r].push_back({last, b});
    endtask

    task automatic push_exp(input int r, input logic [7:0] b, input logic first);
        exp_t e;
        e.idx   = IDX_W'(r);
        e.data  = b;
        e.first = first;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            errors++;
            $display("FAIL drain_%s: pending=%0d busy=%0b after %0d cycles", name, exp_q.size(), busy, n);
            finish_sim();
        end
    endtask

    task automatic wait_locked(input logic level, input string name);
        int n;
        n = 0;
        while (locked !== level && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s: o_Locked stuck at %0b, required %0b", name, locked, level);
            finish_sim();
        end
    endtask

    // Requesters: present the head of each queue, retire it on Ack.
    initial begin
        req_valid = '0;
        req_byte  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int r = 0; r < NUM_REQ; r++) begin
                if (ack[r] && rq[r].size() > 0) void'(rq[r].pop_front());
                if (rq[r].size() > 0) begin
                    req_valid[r]       = 1'b1;
                    req_byte[8*r +: 8] = rq[r][0][7:0];
                    req_last[r]        = rq[r][0][8];
                end else begin
                    req_valid[r] = 1'b0;
                end
            end
        end
    end

    // Transmitter stand-in: Done a random time after DV, occasional stray Done pulses while idle.
    initial begin
        int cnt;
        cnt     = 0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!tx_auto) begin
                cnt     = 0;
                tx_done = 1'b0;
            end else if (tx_dv) begin
                cnt     = $urandom_range(1, 12);
                tx_done = 1'b0;
            end else if (cnt > 1) begin
                cnt--;
                tx_done = 1'b0;
            end else if (cnt == 1) begin
                cnt       = 0;
                tx_done   = 1'b1;
                done_cyc  = cyc;
                have_done = 1'b1;
            end else begin
                tx_done = ($urandom_range(0, 15) == 0);
            end
        end
    end

    // Monitor: every DV pops one expected byte; Ack must coincide with DV.
    initial begin
        exp_t               e;
        logic [NUM_REQ-1:0] oh;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (tx_dv) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_dv: actual byte=%0h grant=%0d, required no issue", tx_byte, grant);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        check("grant_idx", 32'(grant), 32'(e.idx));
                        check("tx_byte", 32'(tx_byte), 32'(e.data));
                        check("ack_onehot", 32'(ack), 32'(oh));
                        check("locked_at_issue", 32'(locked), 32'(!e.first));
                        if (have_done) begin
                            checks++;
                            if (cyc - done_cyc < 3) begin
                                errors++;
                                $display("FAIL done_to_dv_gap: actual=%0d cycles, required>=3", cyc - done_cyc);
                            end
                        end
                        have_done = 1'b0;
                    end
                end else if (ack != '0) begin
                    checks++;
                    errors++;
                    $display("FAIL ack_without_dv: actual ack=%0h, required 0", ack);
                end
            end
        end
    end

    // Reference: whole packets in round-robin order starting after the last served index.
    task automatic random_phase();
        int         npk, len, r;
        bit         any, found, first;
        logic [8:0] x;
        any = 1'b0;
        for (int q = 0; q < NUM_REQ; q++) begin
            npk = $urandom_range(0, 2);
            for (int p = 0; p < npk; p++) begin
                len = $urandom_range(1, 4);
                for (int b = 0; b < len; b++) begin
                    x = {(b == len - 1), 8'($urandom)};
                    rq[q].push_back(x);
                    mq[q].push_back(x);
                    any = 1'b1;
                end
            end
        end
        if (!any) begin
            r = $urandom_range(0, NUM_REQ - 1);
            x = {1'b1, 8'($urandom)};
            rq[r].push_back(x);
            mq[r].push_back(x);
        end
        found = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                r = (model_ptr + k) % NUM_REQ;
                if (!found && mq[r].size() > 0) begin
                    found = 1'b1;
                    first = 1'b1;
                    do begin
                        x = mq[r].pop_front();
                        push_exp(r, x[7:0], first);
                        total_bytes++;
                        first = 1'b0;
                    end while (!x[8]);
                    model_ptr = r;
                end
            end
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_tx_dv", 32'(tx_dv), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_tx_byte", 32'(tx_byte), 0);
        check("rst_grant", 32'(grant), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // Fairness from reset: 10, 11, 12, 13, then 10 again.
        push_req(0, 8'h10, 1'b1); push_req(1, 8'h11, 1'b1);
        push_req(2, 8'h12, 1'b1); push_req(3, 8'h13, 1'b1);
        push_req(0, 8'h10, 1'b1);
        push_exp(0, 8'h10, 1'b1); push_exp(1, 8'h11, 1'b1); push_exp(2, 8'h12, 1'b1);
        push_exp(3, 8'h13, 1'b1); push_exp(0, 8'h10, 1'b1);
        drain("fairness");

        // Packet lock: requester 1's three bytes go out before requester 0.
        push_req(1, 8'hA1, 1'b0); push_req(1, 8'hA2, 1'b0); push_req(1, 8'hA3, 1'b1);
        push_req(0, 8'h50, 1'b1); push_req(0, 8'h51, 1'b1);
        push_exp(1, 8'hA1, 1'b1); push_exp(1, 8'hA2, 1'b0); push_exp(1, 8'hA3, 1'b0);
        push_exp(0, 8'h50, 1'b1); push_exp(0, 8'h51, 1'b1);
        drain("packet_lock");

        // Reset while waiting for the transmitter.
        tx_auto = 1'b0;
        push_req(3, 8'h77, 1'b0);
        push_exp(3, 8'h77, 1'b1);
        n = 0;
        while (!tx_dv && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("reset_test_dv_seen", 32'(tx_dv), 1);
        @(negedge clk);
        check("locked_before_reset", 32'(locked), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_dv", 32'(tx_dv), 0);
        check("midrst_ack", 32'(ack), 0);
        check("midrst_tx_byte", 32'(tx_byte), 0);
        check("midrst_grant", 32'(grant), 0);
        check("midrst_locked", 32'(locked), 0);
        check("midrst_busy", 32'(busy), 0);
        rst       = 1'b0;
        tx_auto   = 1'b1;
        model_ptr = NUM_REQ - 1;
        push_req(2, 8'h32, 1'b1); push_req(1, 8'h31, 1'b1);
        push_exp(1, 8'h31, 1'b1); push_exp(2, 8'h32, 1'b1);
        drain("after_reset");

        // Lock timeout: requester 3 goes silent after one byte; requester 0 follows.
        push_req(3, 8'hC3, 1'b0); push_req(0, 8'hC0, 1'b1);
        push_exp(3, 8'hC3, 1'b1); push_exp(0, 8'hC0, 1'b1);
        wait_locked(1'b1, "timeout_lock_rise");
        wait_locked(1'b0, "timeout_lock_fall");
        check("timeout_release_cycles", 32'(cyc - done_cyc), 32'(LOCK_TIMEOUT + 2));
        drain("timeout");
        model_ptr = 0;

        while (total_bytes < 256) begin
            random_phase();
            drain("random");
        end

        repeat (5) @(negedge clk);
        finish_sim();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares a single `UART_TX` transmitter between `NUM_REQ` byte requesters using round-robin arbitration with optional packet locking. Each requester presents a byte with a valid/ack handshake, and the arbiter sequences them one at a time into the transmitter's `i_TX_DV`/`i_TX_Byte` inputs. The block sits between the on-chip byte sources (debug, status, response engines) and the serial TX pin driver.

## Interface
- `NUM_REQ`, default 4 — number of requesters, 2..8.
- `LOCK_TIMEOUT`, default 1023 — idle clocks a locked requester may hold the grant without presenting a byte. 0 disables the timeout (lock held indefinitely).
- `i_Clock`  in  1  — single clock for this block and the transmitter.
- `i_Rst`  in  1  — reset. One clock; reset is synchronous and active-high.
- `i_Req_Valid`  in  NUM_REQ  — requester n holds a byte pending.
- `i_Req_Byte`  in  8*NUM_REQ  — byte of requester n at bits [8n+7:8n].
- `i_Req_Last`  in  NUM_REQ  — 1 means this byte ends the packet; 0 means keep the grant for the next byte.
- `o_Req_Ack`  out  NUM_REQ  — one-cycle pulse: the byte of requester n was taken.
- `o_TX_DV`  out  1  — to transmitter `i_TX_DV`, one-cycle pulse.
- `o_TX_Byte`  out  8  — to transmitter `i_TX_Byte`. Stable from the `o_TX_DV` pulse until the next issue.
- `i_TX_Done`  in  1  — from transmitter `o_TX_Done`.
- `o_Grant_Idx`  out  $clog2(NUM_REQ)  — current or last granted requester.
- `o_Locked`  out  1  — grant is held for a multi-byte packet.
- `o_Busy`  out  1  — state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT_DONE, GAP, HOLD.
- **IDLE**
  - If any `i_Req_Valid` is set, pick the first valid index searching upward from `rr_ptr+1`, wrapping modulo NUM_REQ.
  - Latch the byte into `o_TX_Byte`, set `o_Grant_Idx`, go to ISSUE.
- **ISSUE** (1 cycle)
  - `o_TX_DV=1` and `o_Req_Ack[grant]=1`.
  - If `i_Req_Last[grant]` was set at latch time, clear `o_Locked` and set `rr_ptr` to grant. Otherwise set `o_Locked`.
  - Go to WAIT_DONE.
- **WAIT_DONE**: wait for `i_TX_Done`, then go to GAP.
- **GAP** (1 cycle, mandatory)
  - Go to HOLD if `o_Locked`, else IDLE.
  - Purpose: guarantees the transmitter has left its CLEANUP state before the next `o_TX_DV`.
- **HOLD**
  - If `i_Req_Valid[grant]` is set: latch its byte and go to ISSUE. Other requesters are ignored.
  - Otherwise increment the timeout counter. At `LOCK_TIMEOUT` (when nonzero): clear `o_Locked`, set `rr_ptr` to grant, go to IDLE.
- Requesters must hold Valid, Byte and Last stable until Ack. Deasserting Valid before Ack is permitted only in IDLE or HOLD; that requester is then simply not selected.
- A requester that has just been served has the lowest priority on the next arbitration. A requester that loses its lock by timeout also has the lowest priority.
- A pulse on `i_TX_Done` in any state other than WAIT_DONE is ignored.

## Timing
- Reset values: state IDLE, `o_TX_DV=0`, `o_Req_Ack=0`, `o_TX_Byte=8'h00`, `o_Grant_Idx=0`, `o_Locked=0`, `o_Busy=0`, `rr_ptr=NUM_REQ-1` (so requester 0 wins first), timeout counter 0.
- Reset mid-operation: all of the above apply on the next edge. The transmitter is reset separately on the same system reset.
- Latency, IDLE with a valid request to `o_TX_DV`: 1 cycle. The request is sampled in IDLE, and DV is asserted during ISSUE.
- Latency, `i_TX_Done` sampled to next `o_TX_DV`: 3 cycles (GAP, then IDLE or HOLD, then ISSUE).
- `o_TX_DV` is a registered full-cycle pulse, so the transmitter samples it on exactly one edge.
- Timeout counter:
  - Width `$clog2(LOCK_TIMEOUT+1)`.
  - Cleared on entry to HOLD.
  - Does not wrap; release happens when the count equals `LOCK_TIMEOUT`.
- Boundary case: all requesters valid simultaneously with `rr_ptr=NUM_REQ-1` → order 0, 1, 2, …, NUM_REQ-1, 0.

## Structure
- Shared package `uart_pkg`: state encoding localparams for `uart_tx_arbiter` and the default UART parameters (`CLKS_PER_BIT`).
- One sub-module, `rr_select`: combinational round-robin picker with `req` and `ptr` inputs and `idx` and `found` outputs. It is reusable by a later RX dispatcher.
- The arbiter does not instantiate `UART_TX`; connection happens at the top level.

## Test plan
- **Single request.** Requester 2 sends 8'hA5 with Last=1.
  - One Ack on index 2.
  - `o_TX_DV` one cycle later with `o_TX_Byte=8'hA5`.
  - Serial output 0,1,0,1,0,0,1,0,1 (start bit then LSB first), then stop bit 1.
- **Fairness.** All 4 requesters hold Last=1 bytes 8'h10..8'h13.
  - Transmit order is 10, 11, 12, 13, 10.
  - Ack pulses are one per DV.
- **Packet lock.** Requester 1 sends 3 bytes (Last=0,0,1) while requester 0 is continuously valid.
  - All 3 bytes of requester 1 are transmitted before any byte from requester 0.
  - `o_Locked` is high from the first ISSUE until the third ISSUE.
- **Lock timeout.** With `LOCK_TIMEOUT=5`, requester 3 sends Last=0 and then goes silent while requester 0 is valid.
  - After 5 HOLD cycles, `o_Locked` drops.
  - Requester 0 is served next.
- **Reset mid-byte.** Assert `i_Rst` during WAIT_DONE.
  - The next cycle shows IDLE with all outputs at their reset values.
  - A new request afterwards is granted to the lowest valid index.
- **Gap check.** Back-to-back bytes: assert ≥3 cycles from `i_TX_Done` to the next `o_TX_DV`, and no byte lost or repeated over 256 random bytes.
